// File: rtl/pipeline_pkg.sv
// Shared types and constants for the ID/EX stage and its hazard scoreboard.
// Optional build macro used by this slice: REGFILE_BYPASS_EN (register-file write-before-read).
package pipeline_pkg;

    localparam int SB_DEPTH = 3;
    localparam int REG_AW   = 5;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_OR   = 4'b0101,
        ALU_AND  = 4'b0110,
        ALU_SLL  = 4'b0111,
        ALU_SRL  = 4'b1000,
        ALU_SRA  = 4'b1001,
        ALU_LUI  = 4'b1111
    } alu_op_e;

    // Width-independent control half of the EX payload; XLEN data lives in the stage.
    typedef struct packed {
        logic [REG_AW-1:0] rd_addr;
        logic [3:0]        alu_control;
        logic              opa_sel;
        logic              opb_sel;
    } idex_payload_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// Tracks destinations of instructions in EX/MEM/WB and flags RAW hazards for decode.
// With REGFILE_BYPASS_EN defined the WB entry is ignored (the register file writes before it reads).
module hazard_scoreboard
    import pipeline_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid_i,
    input  logic              use_rs1_i,
    input  logic              use_rs2_i,
    input  logic [REG_AW-1:0] rs1_addr_i,
    input  logic [REG_AW-1:0] rs2_addr_i,
    input  logic              load_valid_i,
    input  logic [REG_AW-1:0] load_rd_i,
    output logic              hazard_o
);

`ifdef REGFILE_BYPASS_EN
    localparam int CMP_DEPTH = SB_DEPTH - 1;
`else
    localparam int CMP_DEPTH = SB_DEPTH;
`endif

    // Index 0 is EX, 1 is MEM, 2 is WB.
    logic [SB_DEPTH-1:0] sb_valid_q, sb_valid_d;
    logic [REG_AW-1:0]   sb_rd_q [SB_DEPTH];
    logic [REG_AW-1:0]   sb_rd_d [SB_DEPTH];
    logic                hit;

    always_comb begin
        sb_valid_d = {sb_valid_q[SB_DEPTH-2:0], load_valid_i & (load_rd_i != '0)};
        sb_rd_d[0] = load_rd_i;
        for (int i = 1; i < SB_DEPTH; i++) begin
            sb_rd_d[i] = sb_rd_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_valid_q <= '0;
            for (int i = 0; i < SB_DEPTH; i++) begin
                sb_rd_q[i] <= '0;
            end
        end else begin
            sb_valid_q <= sb_valid_d;
            for (int i = 0; i < SB_DEPTH; i++) begin
                sb_rd_q[i] <= sb_rd_d[i];
            end
        end
    end

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < CMP_DEPTH; i++) begin
            if (sb_valid_q[i]) begin
                if (use_rs1_i && (rs1_addr_i != '0) && (rs1_addr_i == sb_rd_q[i])) hit = 1'b1;
                if (use_rs2_i && (rs2_addr_i != '0) && (rs2_addr_i == sb_rd_q[i])) hit = 1'b1;
            end
        end
    end

    assign hazard_o = id_valid_i & hit;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with stall-only RAW resolution and branch flush.
// Optional build macro: REGFILE_BYPASS_EN (shrinks the hazard window by one stage).
module id_ex_stage
    import pipeline_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_rs1_addr,
    input  logic [4:0]      id_rs2_addr,
    input  logic [4:0]      id_rd_addr,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic            id_rd_wren,
    input  logic [3:0]      id_alu_control,
    input  logic            id_opa_sel,
    input  logic            id_opb_sel,
    input  logic            ex_flush,
    output logic            id_stall,
    output logic            ex_valid,
    output logic            ex_rd_wren,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rd_addr,
    output logic [3:0]      ex_alu_control,
    output logic            ex_opa_sel,
    output logic            ex_opb_sel
);

    logic            hazard;
    logic            advance;
    logic            ex_valid_q, ex_valid_d;
    logic            ex_rd_wren_q, ex_rd_wren_d;
    logic [XLEN-1:0] ex_pc_q, ex_pc_d;
    logic [XLEN-1:0] ex_rs1_q, ex_rs1_d;
    logic [XLEN-1:0] ex_rs2_q, ex_rs2_d;
    logic [XLEN-1:0] ex_imm_q, ex_imm_d;
    idex_payload_t   ex_ctrl_q, ex_ctrl_d;

    // A flush kills the decode slot, so it also overrides any stall request.
    assign id_stall = hazard & ~ex_flush;
    assign advance  = ~id_stall & ~ex_flush;

    hazard_scoreboard u_scoreboard (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid_i   (id_valid),
        .use_rs1_i    (id_use_rs1),
        .use_rs2_i    (id_use_rs2),
        .rs1_addr_i   (id_rs1_addr),
        .rs2_addr_i   (id_rs2_addr),
        .load_valid_i (advance & id_valid & id_rd_wren),
        .load_rd_i    (id_rd_addr),
        .hazard_o     (hazard)
    );

    always_comb begin
        ex_valid_d             = 1'b0;
        ex_rd_wren_d           = 1'b0;
        ex_pc_d                = ex_pc_q;
        ex_rs1_d               = ex_rs1_q;
        ex_rs2_d               = ex_rs2_q;
        ex_imm_d               = ex_imm_q;
        ex_ctrl_d              = ex_ctrl_q;
        ex_ctrl_d.alu_control  = ALU_ADD;
        if (advance) begin
            ex_valid_d   = id_valid;
            ex_rd_wren_d = id_rd_wren & id_valid;
            ex_pc_d      = id_pc;
            ex_rs1_d     = id_rs1_data;
            ex_rs2_d     = id_rs2_data;
            ex_imm_d     = id_imm;
            ex_ctrl_d    = '{rd_addr: id_rd_addr, alu_control: id_alu_control,
                             opa_sel: id_opa_sel, opb_sel: id_opb_sel};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q   <= 1'b0;
            ex_rd_wren_q <= 1'b0;
            ex_pc_q      <= '0;
            ex_rs1_q     <= '0;
            ex_rs2_q     <= '0;
            ex_imm_q     <= '0;
            ex_ctrl_q    <= '0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_rd_wren_q <= ex_rd_wren_d;
            ex_pc_q      <= ex_pc_d;
            ex_rs1_q     <= ex_rs1_d;
            ex_rs2_q     <= ex_rs2_d;
            ex_imm_q     <= ex_imm_d;
            ex_ctrl_q    <= ex_ctrl_d;
        end
    end

    assign ex_valid       = ex_valid_q;
    assign ex_rd_wren     = ex_rd_wren_q;
    assign ex_pc          = ex_pc_q;
    assign ex_rs1_data    = ex_rs1_q;
    assign ex_rs2_data    = ex_rs2_q;
    assign ex_imm         = ex_imm_q;
    assign ex_rd_addr     = ex_ctrl_q.rd_addr;
    assign ex_alu_control = ex_ctrl_q.alu_control;
    assign ex_opa_sel     = ex_ctrl_q.opa_sel;
    assign ex_opb_sel     = ex_ctrl_q.opb_sel;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard scenarios plus a random stream
// checked against a "cycles since last write" register model.
module tb_id_ex_stage;

    localparam int XLEN = 32;
`ifdef REGFILE_BYPASS_EN
    localparam int WINDOW = 2;
`else
    localparam int WINDOW = 3;
`endif

    logic            clk, rst_n;
    logic            id_valid, id_use_rs1, id_use_rs2, id_rd_wren, id_opa_sel, id_opb_sel;
    logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]      id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [3:0]      id_alu_control;
    logic            ex_flush, id_stall;
    logic            ex_valid, ex_rd_wren, ex_opa_sel, ex_opb_sel;
    logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]      ex_rd_addr;
    logic [3:0]      ex_alu_control;

    id_ex_stage #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd_wren(id_rd_wren),
        .id_alu_control(id_alu_control), .id_opa_sel(id_opa_sel), .id_opb_sel(id_opb_sel),
        .ex_flush(ex_flush), .id_stall(id_stall), .ex_valid(ex_valid), .ex_rd_wren(ex_rd_wren),
        .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rd_addr(ex_rd_addr), .ex_alu_control(ex_alu_control),
        .ex_opa_sel(ex_opa_sel), .ex_opb_sel(ex_opb_sel)
    );

    // ---------------- clock / reset / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // ---------------- reference model state ----------------
    typedef struct {
        logic [XLEN-1:0] pc, rs1d, rs2d, imm;
        logic [4:0]      rs1, rs2, rd;
        logic            use1, use2, wren, opa, opb;
        logic [3:0]      alu;
    } instr_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_wr [32];   // cycle at which each register's writer entered EX

    function automatic void model_reset();
        for (int r = 0; r < 32; r++) last_wr[r] = -100;
    endfunction

    function automatic instr_t mk(input logic [3:0] alu, input logic [4:0] rd, input logic [4:0] rs1,
                                  input logic [4:0] rs2, input logic use1, input logic use2,
                                  input logic wren, input logic opb);
        instr_t ins;
        ins.pc   = $urandom & 32'hFFFF_FFFC;
        ins.rs1d = $urandom;
        ins.rs2d = $urandom;
        ins.imm  = $urandom;
        ins.rs1  = rs1;  ins.rs2 = rs2;  ins.rd = rd;
        ins.use1 = use1; ins.use2 = use2; ins.wren = wren;
        ins.opa  = 1'($urandom_range(0, 1));
        ins.opb  = opb;
        ins.alu  = alu;
        return ins;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic present(input instr_t ins);
        id_valid = 1'b1;
        id_pc = ins.pc; id_rs1_data = ins.rs1d; id_rs2_data = ins.rs2d; id_imm = ins.imm;
        id_rs1_addr = ins.rs1; id_rs2_addr = ins.rs2; id_rd_addr = ins.rd;
        id_use_rs1 = ins.use1; id_use_rs2 = ins.use2; id_rd_wren = ins.wren;
        id_alu_control = ins.alu; id_opa_sel = ins.opa; id_opb_sel = ins.opb;
    endtask

    // One clock of the current inputs, checked against the model. Called at posedge+1.
    task automatic drive_cycle(output bit advanced, output bit stall_seen);
        bit hz, exp_stall, exp_adv;
        logic [XLEN*4+5+4+2-1:0] exp_pay, got_pay;
        hz = 1'b0;
        if (id_valid) begin
            if (id_use_rs1 && id_rs1_addr != 0 && (cyc - last_wr[id_rs1_addr]) <= WINDOW) hz = 1'b1;
            if (id_use_rs2 && id_rs2_addr != 0 && (cyc - last_wr[id_rs2_addr]) <= WINDOW) hz = 1'b1;
        end
        exp_stall = hz && !ex_flush;
        exp_adv   = !exp_stall && !ex_flush;
        @(negedge clk);
        stall_seen = id_stall;
        total++;
        if (id_stall !== exp_stall) begin
            bad++;
            $display("FAIL id_stall cyc=%0d got=%b exp=%b", cyc, id_stall, exp_stall);
        end
        exp_pay = {id_pc, id_rs1_data, id_rs2_data, id_imm, id_rd_addr, id_alu_control,
                   id_opa_sel, id_opb_sel};
        @(posedge clk);
        #1;
        if (exp_adv) begin
            total++;
            if ({ex_valid, ex_rd_wren} !== {id_valid, id_valid & id_rd_wren}) begin
                bad++;
                $display("FAIL ex_ctrl cyc=%0d got=%b%b exp=%b%b", cyc, ex_valid, ex_rd_wren,
                         id_valid, id_valid & id_rd_wren);
            end
            got_pay = {ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rd_addr, ex_alu_control,
                       ex_opa_sel, ex_opb_sel};
            total++;
            if (got_pay !== exp_pay) begin
                bad++;
                $display("FAIL ex_payload cyc=%0d got=%h exp=%h", cyc, got_pay, exp_pay);
            end
            if (id_valid && id_rd_wren && id_rd_addr != 0) last_wr[id_rd_addr] = cyc;
        end else begin
            total++;
            if ({ex_valid, ex_rd_wren, ex_alu_control} !== 6'b0) begin
                bad++;
                $display("FAIL bubble cyc=%0d got=%b%b/%b exp=00/0000", cyc, ex_valid, ex_rd_wren,
                         ex_alu_control);
            end
        end
        cyc++;
        advanced = exp_adv;
    endtask

    // Present an instruction and re-present it until it advances; returns observed stalls.
    task automatic issue(input instr_t ins, output int stalls);
        bit adv, st;
        adv = 1'b0;
        present(ins);
        stalls = 0;
        for (int k = 0; k < 8; k++) begin
            drive_cycle(adv, st);
            if (st) stalls++;
            if (adv) break;
        end
        if (!adv) begin
            total++;
            bad++;
            $display("FAIL issue_timeout got=stalled exp=advance within 8 cycles");
        end
    endtask

    task automatic drain();
        bit adv, st;
        id_valid = 1'b0;
        ex_flush = 1'b0;
        repeat (4) drive_cycle(adv, st);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        present(mk(4'b0101, 5'd3, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL rst_ex_valid got=%b exp=0", ex_valid); end
        total++; if (ex_rd_wren !== 1'b0) begin bad++; $display("FAIL rst_ex_rd_wren got=%b exp=0", ex_rd_wren); end
        total++; if (ex_alu_control !== 4'b0) begin bad++; $display("FAIL rst_alu got=%b exp=0000", ex_alu_control); end
        total++; if (ex_pc !== '0) begin bad++; $display("FAIL rst_pc got=%h exp=0", ex_pc); end
        total++; if (ex_rs1_data !== '0) begin bad++; $display("FAIL rst_rs1 got=%h exp=0", ex_rs1_data); end
        total++; if (ex_rs2_data !== '0) begin bad++; $display("FAIL rst_rs2 got=%h exp=0", ex_rs2_data); end
        total++; if (ex_imm !== '0) begin bad++; $display("FAIL rst_imm got=%h exp=0", ex_imm); end
        total++; if (ex_rd_addr !== 5'd0) begin bad++; $display("FAIL rst_rd got=%0d exp=0", ex_rd_addr); end
        total++; if ({ex_opa_sel, ex_opb_sel} !== 2'b0) begin bad++; $display("FAIL rst_sel got=%b%b exp=00", ex_opa_sel, ex_opb_sel); end
        total++; if (id_stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", id_stall); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        id_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        int s;
        drain();
        issue(mk(4'b0000, 5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0), s);
        issue(mk(4'b0001, 5'd6, 5'd5, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0), s);
        total++; if (s != WINDOW) begin bad++; $display("FAIL b2b_stalls got=%0d exp=%0d", s, WINDOW); end
        total++;
        if ({ex_valid, ex_alu_control} !== 5'b1_0001) begin
            bad++;
            $display("FAIL b2b_sub_in_ex got=%b/%b exp=1/0001", ex_valid, ex_alu_control);
        end
    endtask

    task automatic test_x0();
        int s1, s2;
        drain();
        issue(mk(4'b0000, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1), s1);
        total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL x0_first_valid got=%b exp=1", ex_valid); end
        issue(mk(4'b0000, 5'd7, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0), s2);
        total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL x0_second_valid got=%b exp=1", ex_valid); end
        total++; if (s1 + s2 != 0) begin bad++; $display("FAIL x0_stalls got=%0d exp=0", s1 + s2); end
    endtask

    task automatic test_distance();
        int s, exp_s;
        for (int d = 2; d <= 4; d++) begin
            drain();
            issue(mk(4'b1111, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1), s);
            for (int f = 1; f < d; f++)
                issue(mk(4'b0110, 5'd20, 5'd21, 5'd22, 1'b1, 1'b1, 1'b0, 1'b0), s);
            issue(mk(4'b0100, 5'd11, 5'd4, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0), s);
            exp_s = (WINDOW + 1 - d > 0) ? WINDOW + 1 - d : 0;
            total++; if (s != exp_s) begin bad++; $display("FAIL dist%0d_stalls got=%0d exp=%0d", d, s, exp_s); end
        end
    endtask

    task automatic test_independent();
        int s, sum;
        drain();
        sum = 0;
        for (int k = 0; k < 20; k++) begin
            issue(mk(4'b0101, 5'd8, 5'd9, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0), s);
            sum += s;
        end
        total++; if (sum != 0) begin bad++; $display("FAIL indep_stalls got=%0d exp=0", sum); end
    endtask

    task automatic test_flush_stall();
        int s;
        bit adv, st;
        drain();
        issue(mk(4'b0000, 5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0), s);
        present(mk(4'b0001, 5'd6, 5'd5, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0));
        ex_flush = 1'b1;
        drive_cycle(adv, st);
        ex_flush = 1'b0;
        total++; if (st !== 1'b0) begin bad++; $display("FAIL flush_stall got=%b exp=0", st); end
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL flush_ex_valid got=%b exp=0", ex_valid); end
        issue(mk(4'b0000, 5'd7, 5'd6, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0), s);
        total++; if (s != 0) begin bad++; $display("FAIL flush_follow_stalls got=%0d exp=0", s); end
    endtask

    task automatic test_reset_mid_stall();
        int s;
        bit adv, st;
        instr_t sub;
        drain();
        issue(mk(4'b0000, 5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0), s);
        sub = mk(4'b0001, 5'd6, 5'd5, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0);
        present(sub);
        drive_cycle(adv, st);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({ex_valid, ex_rd_wren, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rd_addr,
             ex_opa_sel, ex_opb_sel, id_stall} !== '0) begin
            bad++;
            $display("FAIL midrst_outputs got=%b%b pc=%h exp=all zero", ex_valid, ex_rd_wren, ex_pc);
        end
        total++; if (ex_alu_control !== 4'b0) begin bad++; $display("FAIL midrst_alu got=%b exp=0000", ex_alu_control); end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue(sub, s);
        total++; if (s != 0) begin bad++; $display("FAIL midrst_after_stalls got=%0d exp=0", s); end
    endtask

    task automatic test_random();
        bit adv, st;
        adv = 1'b1;
        drain();
        for (int k = 0; k < 300; k++) begin
            if (adv || ex_flush || !id_valid) begin
                present(mk(4'($urandom_range(0, 15)), 5'($urandom_range(0, 7)),
                           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))));
                id_valid = ($urandom_range(0, 7) != 0);
            end
            ex_flush = ($urandom_range(0, 9) == 0);
            drive_cycle(adv, st);
        end
        ex_flush = 1'b0;
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        rst_n = 1'b0;
        ex_flush = 1'b0;
        id_valid = 1'b0;
        model_reset();
        test_reset();
        test_back_to_back();
        test_x0();
        test_distance();
        test_independent();
        test_flush_stall();
        test_reset_mid_stall();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
